// File: rtl/wtm_mac_pkg.sv
// Shared widths, FSM state encoding and operand payload for the WTM multiply-accumulate unit.
package wtm_mac_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned PROD_W = 10;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/wtm_mac_if.sv
// Operand-in / sum-out valid-ready bus of the WTM multiply-accumulate unit.
interface wtm_mac_if #(
  parameter int unsigned ACC_W = 16
);
  import wtm_mac_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/wtm_mac_unit_wtm.sv
// WTM: 5x5 unsigned Wallace-tree multiplier, carry-save reduction of five partial products.
module WTM
  import wtm_mac_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] mul,
  output logic              cout
);

  localparam int unsigned W = PROD_W + 1;

  // 3:2 compressor on full rows; returns {sum, carry}
  function automatic logic [2*W-1:0] csa(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] z);
    logic [W-1:0] s;
    logic [W-1:0] c;
    s = x ^ y ^ z;
    c = {(x[W-2:0] & y[W-2:0]) | (x[W-2:0] & z[W-2:0]) | (y[W-2:0] & z[W-2:0]), 1'b0};
    return {s, c};
  endfunction

  logic [W-1:0] pp [OP_W];
  logic [W-1:0] s1, c1, s2, c2, s3, c3, total;

  always_comb begin
    for (int i = 0; i < int'(OP_W); i++) begin
      pp[i] = W'(a & {OP_W{b[i]}}) << i;
    end
  end

  assign {s1, c1} = csa(pp[0], pp[1], pp[2]);
  assign {s2, c2} = csa(s1, c1, pp[3]);
  assign {s3, c3} = csa(s2, c2, pp[4]);
  assign total    = s3 + c3;
  assign mul      = total[PROD_W-1:0];
  assign cout     = total[PROD_W];

endmodule

// File: rtl/wtm_mac_unit.sv
// Streaming frame multiply-accumulate around one WTM multiplier: P1 operands -> P2 product -> ACC.
// Build option WTM_MAC_SATURATE_EN: clamp the accumulator to all ones on overflow instead of wrapping.
module wtm_mac_unit
  import wtm_mac_pkg::*;
#(
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = 16
) (
  input  logic      clock,
  input  logic      resetn,
  wtm_mac_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   in_cnt;
  op_pair_t           p1;
  logic               p1_valid;
  logic [PROD_W-1:0]  p2_prod;
  logic               p2_valid;
  logic [PROD_W-1:0]  wtm_mul;
  logic               wtm_cout;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               accept_c;
  logic               consume_c;
  logic [SUM_W-1:0]   add_c;

  assign accept_c  = bus.in_valid & in_ready_q;
  assign consume_c = out_valid_q & bus.out_ready;
  assign add_c     = {1'b0, acc} + SUM_W'(p2_prod);

  WTM u_wtm (
    .a    (p1.a),
    .b    (p1.b),
    .mul  (wtm_mul),
    .cout (wtm_cout)
  );

  // A 5x5 product never exceeds 10 bits, so the multiplier carry must stay low
  a_cout_zero: assert property (@(posedge clock) disable iff (!resetn) wtm_cout == 1'b0);

  // Next-state: DRAIN ends on the edge that folds the last product into ACC
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (accept_c && (in_cnt == LAST_CNT)) state_nxt = DRAIN;
      DRAIN:   if (p2_valid && !p1_valid)            state_nxt = DONE;
      DONE:    if (consume_c)                        state_nxt = COLLECT;
      default:                                       state_nxt = COLLECT;
    endcase
  end

  // out_valid is held back one cycle after entering DONE to give the fixed 3-edge latency
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= COLLECT;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      in_cnt      <= '0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt == COLLECT);
      out_valid_q <= (state_nxt == DONE) && (state == DONE);
      if (consume_c)     in_cnt <= '0;
      else if (accept_c) in_cnt <= in_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      p1_valid <= 1'b0;
      p1       <= '0;
      p2_valid <= 1'b0;
      p2_prod  <= '0;
    end else begin
      p1_valid <= accept_c;
      if (accept_c) p1 <= '{a: bus.in_a, b: bus.in_b};
      p2_valid <= p1_valid;
      if (p1_valid) p2_prod <= wtm_mul;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (consume_c) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (p2_valid) begin
      if (add_c[ACC_W]) ovf <= 1'b1;
`ifdef WTM_MAC_SATURATE_EN
      acc <= add_c[ACC_W] ? '1 : add_c[ACC_W-1:0];
`else
      acc <= add_c[ACC_W-1:0];
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;

endmodule

// File: tb/tb_wtm_mac_unit.sv
// Directed bench for wtm_mac_unit: three instances (LEN4/ACC16, LEN4/ACC10, LEN1/ACC16) on one stimulus bus.
module tb_wtm_mac_unit;

  logic       clock = 1'b0;
  logic       resetn;
  logic       tv;
  logic       tor;
  logic [4:0] ta;
  logic [4:0] tbv;
  int         sel;

  logic        rdy;
  logic        oval;
  logic        oovf;
  logic [15:0] osum;

  int errs   = 0;
  int checks = 0;
  int cyc;

  always #5 clock = ~clock;

  wtm_mac_if #(.ACC_W(16)) if0 ();
  wtm_mac_if #(.ACC_W(10)) if1 ();
  wtm_mac_if #(.ACC_W(16)) if2 ();

  assign if0.in_valid  = tv && (sel == 0);
  assign if1.in_valid  = tv && (sel == 1);
  assign if2.in_valid  = tv && (sel == 2);
  assign if0.out_ready = tor && (sel == 0);
  assign if1.out_ready = tor && (sel == 1);
  assign if2.out_ready = tor && (sel == 2);
  assign if0.in_a = ta;  assign if0.in_b = tbv;
  assign if1.in_a = ta;  assign if1.in_b = tbv;
  assign if2.in_a = ta;  assign if2.in_b = tbv;

  assign rdy  = (sel == 0) ? if0.in_ready  : (sel == 1) ? if1.in_ready  : if2.in_ready;
  assign oval = (sel == 0) ? if0.out_valid : (sel == 1) ? if1.out_valid : if2.out_valid;
  assign oovf = (sel == 0) ? if0.out_ovf   : (sel == 1) ? if1.out_ovf   : if2.out_ovf;
  assign osum = (sel == 0) ? if0.out_sum   : (sel == 1) ? 16'(if1.out_sum) : if2.out_sum;

  wtm_mac_unit #(.LEN(4), .ACC_W(16)) dut0 (.clock(clock), .resetn(resetn), .bus(if0.slave));
  wtm_mac_unit #(.LEN(4), .ACC_W(10)) dut1 (.clock(clock), .resetn(resetn), .bus(if1.slave));
  wtm_mac_unit #(.LEN(1), .ACC_W(16)) dut2 (.clock(clock), .resetn(resetn), .bus(if2.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one pair, wait (bounded) for in_ready, return #1 after the accepting edge
  task automatic send(input logic [4:0] a, input logic [4:0] b, input int gap, input bit keep);
    int w;
    repeat (gap) begin @(posedge clock); #1; end
    tv = 1'b1; ta = a; tbv = b; w = 0;
    while (!rdy && w < 50) begin @(posedge clock); #1; w++; end
    if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
    @(posedge clock); #1;
    if (!keep) begin
      tv = 1'b0; ta = 5'h1f; tbv = 5'h1f;
    end
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!oval && n < 20) begin @(posedge clock); #1; n++; end
  endtask

  task automatic consume();
    tor = 1'b1;
    @(posedge clock); #1;
    tor = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; tv = 1'b0; tor = 1'b0; ta = '0; tbv = '0; sel = 0;
    repeat (2) @(posedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      sel = k; #1;
      check("rst_in_ready",  32'(rdy),  32'd1);
      check("rst_out_valid", 32'(oval), 32'd0);
      check("rst_out_sum",   32'(osum), 32'd0);
      check("rst_out_ovf",   32'(oovf), 32'd0);
    end
    sel = 0;
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    // Back-to-back frame: 15 + 961 + 0 + 1
    send(5'd3, 5'd5, 0, 1'b0);
    send(5'd31, 5'd31, 0, 1'b0);
    send(5'd0, 5'd7, 0, 1'b0);
    send(5'd1, 5'd1, 0, 1'b0);
    check("b2b_drain_in_ready", 32'(rdy), 32'd0);
    wait_out(cyc);
    check("b2b_latency", 32'(cyc),  32'd3);
    check("b2b_sum",     32'(osum), 32'd977);
    check("b2b_ovf",     32'(oovf), 32'd0);

    // Consumer stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("hold_valid",    32'(oval), 32'd1);
      check("hold_sum",      32'(osum), 32'd977);
      check("hold_in_ready", 32'(rdy),  32'd0);
    end
    consume();
    check("consume_in_ready",  32'(rdy),  32'd1);
    check("consume_out_valid", 32'(oval), 32'd0);

    // Gapped frame: 4 + 16 + 36 + 64; in_valid stays high through DRAIN/DONE
    send(5'd2, 5'd2, 1, 1'b0);
    send(5'd4, 5'd4, 0, 1'b0);
    send(5'd6, 5'd6, 3, 1'b0);
    send(5'd8, 5'd8, 2, 1'b1);
    ta = 5'd31; tbv = 5'd31;
    wait_out(cyc);
    check("gap_latency",  32'(cyc),  32'd3);
    check("gap_sum",      32'(osum), 32'd120);
    check("gap_ovf",      32'(oovf), 32'd0);
    check("gap_in_ready", 32'(rdy),  32'd0);
    repeat (2) begin @(posedge clock); #1; end
    check("gap_stall_sum", 32'(osum), 32'd120);
    tv = 1'b0;
    consume();

    // 10-bit accumulator overflow: 4 x 961
    sel = 1; #1;
    for (int i = 0; i < 4; i++) send(5'd31, 5'd31, 0, 1'b0);
    wait_out(cyc);
    check("ovf_latency", 32'(cyc), 32'd3);
`ifdef WTM_MAC_SATURATE_EN
    check("ovf_sum", 32'(osum), 32'd1023);
`else
    check("ovf_sum", 32'(osum), 32'd772);
`endif
    check("ovf_flag", 32'(oovf), 32'd1);
    consume();
    check("ovf_cleared", 32'(oovf), 32'd0);

    // Reset mid-frame after two accepts
    sel = 0; #1;
    send(5'd5, 5'd5, 0, 1'b0);
    send(5'd5, 5'd5, 0, 1'b0);
    repeat (3) begin @(posedge clock); #1; end
    resetn = 1'b0; #1;
    check("midrst_out_valid", 32'(oval), 32'd0);
    check("midrst_out_sum",   32'(osum), 32'd0);
    check("midrst_in_ready",  32'(rdy),  32'd1);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) send(5'd1, 5'd1, 0, 1'b0);
    wait_out(cyc);
    check("postrst_latency", 32'(cyc),  32'd3);
    check("postrst_sum",     32'(osum), 32'd4);
    consume();

    // LEN=1: first accept enters DRAIN
    sel = 2; #1;
    send(5'd31, 5'd31, 0, 1'b0);
    check("len1_drain_in_ready", 32'(rdy), 32'd0);
    wait_out(cyc);
    check("len1_latency", 32'(cyc),  32'd3);
    check("len1_sum",     32'(osum), 32'd961);
    check("len1_ovf",     32'(oovf), 32'd0);
    consume();
    check("len1_back_in_ready", 32'(rdy), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
